window_scan_feeder: RTL and testbench
=====================================

// Module: window_scan_feeder
// PURPOSE
//  Write side of buffer5x5: walks an IMG_W x IMG_H 8-bit image in serpentine order and fetches pixels from frame memory.
//  Drives buffer5x5 with 5-pixel columns/rows plus shift_enable/shift_direction, then flags each complete 5x5 window.
//  Sits between frame memory and the buffer5x5 -> Gaussian/Sobel stages of the canny pipeline.
// PARAMETERS
//  IMG_W   16  image width in pixels, >=5
//  IMG_H   12  image height in pixels, >=5
//  ADDR_W  $clog2(IMG_W*IMG_H)  frame-memory address width
// PORTS
//  clk              in   1        system clock
//  n_rst            in   1        async active-low reset
//  start            in   1        begin a frame scan; ignored while busy=1
//  hold             in   1        downstream stall; blocks only the shift cycle
//  mem_ren          out  1        frame-memory read strobe
//  mem_addr         out  ADDR_W   read address = y*IMG_W + x
//  mem_rdata        in   8        read data, valid exactly 1 cycle after mem_ren
//  shift_enable     out  1        one-cycle shift strobe to buffer5x5
//  shift_direction  out  2        00 none, 01 right, 10 left, 11 down
//  buffer_input     out  5x8      [k]: row k (01/10) or column k (11) of new slice
//  window_valid     out  1        one-cycle pulse: buffer5x5 holds a new full window
//  win_x, win_y     out  8 each   window centre coordinates, valid with window_valid
//  busy             out  1        scan in progress
//  done             out  1        one-cycle pulse after the final window
// BEHAVIOUR
//  Clock and reset:
//   - Single clock domain.
//   - Asynchronous reset on n_rst low: all outputs 0, buffer_input all 0, direction 00, FSM IDLE.
//   - Reset mid-scan aborts the scan; no done pulse is issued.
//  FSM: IDLE -> FETCH -> CAPTURE -> SHIFT -> (FETCH | FINISH) ; FINISH -> IDLE.
//   IDLE:    start=1 latches position x=0, y=0, fill=0; busy=1 next cycle.
//   FETCH:   5 cycles, k=0..4, mem_ren=1.
//            Column slice: address (x, y+k). Row slice: address (x+k, y+4).
//            mem_rdata is captured into buffer_input[k-1] on cycle k.
//   CAPTURE: 1 cycle; captures k=4. mem_ren=0.
//   SHIFT:   shift_enable=1 with shift_direction while hold=0.
//            While hold=1: stay in SHIFT, shift_enable=0, buffer_input held stable.
//   Per-slice latency: 7 cycles when hold=0.
//  Scan order, tracked as top-left corner (tx, ty):
//   - Fill: 5 column slices x=0..4, direction 01. window_valid only after the 5th shift.
//   - Even window row: direction 01, new column x = tx+5, until tx = IMG_W-5.
//   - Odd window row: direction 10, new column x = tx-1, until tx = 0.
//   - At a row end with ty < IMG_H-5: one down shift, direction 11, new row y = ty+5, columns tx..tx+4.
//   - At a row end with ty = IMG_H-5: go to FINISH; done=1 for one cycle, busy=0.
//  Outputs per shift:
//   - window_valid pulses the cycle after each post-fill shift_enable.
//   - win_x = tx+2 and win_y = ty+2, using the updated corner.
//   - Total window_valid pulses per frame = (IMG_W-4)*(IMG_H-4).
//  Boundary and edge cases:
//   - IMG_W=5: no horizontal moves; down shifts only.
//   - IMG_H=5: single window row.
//   - Simultaneous start with done: start is ignored, since busy is still 1 in that cycle.
//   - shift_direction holds its last value between strobes; buffer5x5 ignores it while shift_enable=0.
//   - Address arithmetic is unsigned ADDR_W bits. Generated coordinates never leave the image.
// STRUCTURE
//  canny_pkg:
//   - typedef pixel_t (logic [7:0]).
//   - enum dir_t: DIR_NONE=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11.
//   - localparam WIN=5. Shared with buffer5x5 and its testbench.
//  Sub-module scan_addr_gen: from (tx, ty, k, dir) produces pixel (x, y) and mem_addr.
//  FSM, corner counters and capture registers stay in the top.
// TESTING  (IMG_W=8, IMG_H=6; memory model returns (y*8+x)&8'hFF)
//  1. Reset mid-FETCH -> mem_ren=0, shift_enable=0, busy=0 immediately; no done; new start re-fills from (0,0).
//  2. First fill strobe: buffer_input={0,8,16,24,32}, dir 01, 7 cycles after start.
//     First window_valid after the 5th strobe with win_x=2, win_y=2.
//  3. Full frame, hold=0: strobe dirs 01x5, 01x3, 11, 10x3 (12 strobes, 7 cycles apart).
//     Exactly 8 window_valid pulses. Last pulse win=(2,3). done follows.
//  4. Down strobe from corner (3,0): buffer_input={43,44,45,46,47}.
//     Next left strobe: {10,18,26,34,42}.
//  5. hold=1 for 10 cycles while in SHIFT: shift_enable stays 0 and buffer_input stays stable.
//     Strobe occurs the cycle hold falls; total frame time grows by exactly 10 cycles.
//  6. start pulsed while busy -> ignored, scan and window count unchanged.
//     IMG_W=5, IMG_H=5 -> 5 strobes, 1 window_valid at (2,2), then done.

Source files
------------

// File: rtl/window_scan_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : window_scan_feeder_pkg                                           |
// | Purpose : Shared types for the 5x5 window feeder and the buffer5x5 stage:  |
// |           pixel type, shift-direction encoding and window size.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package window_scan_feeder_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_t;

   localparam int WIN = 5;

endpackage
`default_nettype wire

// File: rtl/window_scan_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : window_scan_feeder_if                                          |
// | Purpose   : Bundles the feeder's control, frame-memory read port and       |
// |             buffer5x5 write-side signals.                                  |
// | Signals   : start, hold            - scan request / downstream stall       |
// |             mem_ren, mem_addr,     - frame-memory read (data 1 cycle later)|
// |             mem_rdata                                                      |
// |             shift_enable,          - slice strobe, direction and 5 pixels  |
// |             shift_direction,                                               |
// |             buffer_input                                                   |
// |             window_valid, win_x,   - new full window and its centre        |
// |             win_y                                                          |
// |             busy, done             - scan status                           |
// | Modports  : master = feeder, slave = surrounding logic                     |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface window_scan_feeder_if #(
   parameter int ADDR_W = 8
);
   import window_scan_feeder_pkg::*;

   logic                  start;
   logic                  hold;
   logic                  mem_ren;
   logic [ADDR_W-1:0]     mem_addr;
   pixel_t                mem_rdata;
   logic                  shift_enable;
   dir_t                  shift_direction;
   pixel_t [WIN-1:0]      buffer_input;
   logic                  window_valid;
   logic [7:0]            win_x;
   logic [7:0]            win_y;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, hold, mem_rdata,
      output mem_ren, mem_addr, shift_enable, shift_direction, buffer_input,
             window_valid, win_x, win_y, busy, done
   );

   modport slave (
      output start, hold, mem_rdata,
      input  mem_ren, mem_addr, shift_enable, shift_direction, buffer_input,
             window_valid, win_x, win_y, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/window_scan_feeder_scan_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scan_addr_gen                                                    |
// | Purpose : Maps the current slice (corner tx/ty, element k, direction) to   |
// |           a pixel coordinate and its frame-memory address y*IMG_W + x.     |
// | Ports   : i_tx, i_ty    - window top-left corner before the shift          |
// |           i_k           - element index within the slice (0..4)            |
// |           i_dir         - direction of the slice being fetched             |
// |           i_fill        - initial fill phase (columns 0..4)                |
// |           i_fill_col    - fill column index                                |
// |           o_addr        - frame-memory address                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module scan_addr_gen
   import window_scan_feeder_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int ADDR_W = 8
) (
   input  logic [7:0]        i_tx,
   input  logic [7:0]        i_ty,
   input  logic [2:0]        i_k,
   input  dir_t              i_dir,
   input  logic              i_fill,
   input  logic [2:0]        i_fill_col,
   output logic [ADDR_W-1:0] o_addr
);

   logic [7:0] w_x;
   logic [7:0] w_y;
   logic [7:0] w_k;

   assign w_k = {5'd0, i_k};

   // Column slices run down y = ty..ty+4 at one x; the down slice runs
   // along x = tx..tx+4 on the row just below the current window.
   always_comb begin
      w_x = i_tx;
      w_y = i_ty;
      if (i_fill) begin
         w_x = {5'd0, i_fill_col};
         w_y = i_ty + w_k;
      end else begin
         case (i_dir)
            DIR_RIGHT: begin
               w_x = i_tx + 8'(WIN);
               w_y = i_ty + w_k;
            end
            DIR_LEFT: begin
               w_x = i_tx - 8'd1;
               w_y = i_ty + w_k;
            end
            DIR_DOWN: begin
               w_x = i_tx + w_k;
               w_y = i_ty + 8'(WIN);
            end
            default: begin
               w_x = i_tx;
               w_y = i_ty;
            end
         endcase
      end
   end

   assign o_addr = ADDR_W'(w_y) * ADDR_W'(IMG_W) + ADDR_W'(w_x);

endmodule
`default_nettype wire

// File: rtl/window_scan_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : window_scan_feeder                                               |
// | Purpose : Walks an IMG_W x IMG_H image in serpentine window order, reads   |
// |           5-pixel slices from frame memory and strobes them into           |
// |           buffer5x5, flagging every complete 5x5 window.                   |
// | Ports   : clk    - system clock                                            |
// |           n_rst  - asynchronous active-low reset                           |
// |           bus    - window_scan_feeder_if.master (control, memory, buffer)  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module window_scan_feeder
   import window_scan_feeder_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 12,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   window_scan_feeder_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_SHIFT   = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   localparam logic [7:0] c_tx_last  = 8'(IMG_W - WIN);
   localparam logic [7:0] c_ty_last  = 8'(IMG_H - WIN);
   localparam logic [2:0] c_k_last   = 3'(WIN - 1);
   localparam logic [2:0] c_fill_len = 3'(WIN);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_tx;
   logic [7:0]        r_ty;
   logic              r_odd;          // current window row runs right-to-left
   logic [2:0]        r_fill;         // fill shifts completed (saturates at WIN)
   logic [2:0]        r_k;
   dir_t              r_dir;          // direction of the slice being fetched
   dir_t              r_shift_dir;    // direction presented to buffer5x5
   pixel_t [WIN-1:0]  r_buf;
   logic              r_win_valid;
   logic [7:0]        r_win_x;
   logic [7:0]        r_win_y;

   logic              w_filling;
   logic              w_shift_fire;
   logic [7:0]        w_tx_nxt;
   logic [7:0]        w_ty_nxt;
   logic              w_odd_nxt;
   logic [2:0]        w_fill_nxt;
   logic              w_row_end;
   logic              w_last_slice;
   dir_t              w_dir_nxt;
   logic [ADDR_W-1:0] w_addr;

   assign w_filling = (r_fill < c_fill_len);

   scan_addr_gen #(
      .IMG_W  (IMG_W),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_tx       (r_tx),
      .i_ty       (r_ty),
      .i_k        (r_k),
      .i_dir      (r_dir),
      .i_fill     (w_filling),
      .i_fill_col (r_fill),
      .o_addr     (w_addr)
   );

   // Corner after the pending shift and the slice that follows it. Evaluated
   // every cycle; only committed when the shift actually fires.
   always_comb begin
      w_tx_nxt   = r_tx;
      w_ty_nxt   = r_ty;
      w_odd_nxt  = r_odd;
      w_fill_nxt = r_fill;
      if (w_filling) begin
         w_fill_nxt = r_fill + 3'd1;
      end else begin
         case (r_dir)
            DIR_RIGHT: w_tx_nxt = r_tx + 8'd1;
            DIR_LEFT:  w_tx_nxt = r_tx - 8'd1;
            DIR_DOWN: begin
               w_ty_nxt  = r_ty + 8'd1;
               w_odd_nxt = ~r_odd;
            end
            default: w_tx_nxt = r_tx;
         endcase
      end

      w_row_end    = w_odd_nxt ? (w_tx_nxt == 8'd0) : (w_tx_nxt == c_tx_last);
      w_last_slice = 1'b0;
      w_dir_nxt    = DIR_RIGHT;
      if (w_fill_nxt < c_fill_len) begin
         w_dir_nxt = DIR_RIGHT;
      end else if (w_row_end) begin
         if (w_ty_nxt < c_ty_last) begin
            w_dir_nxt = DIR_DOWN;
         end else begin
            w_last_slice = 1'b1;
         end
      end else begin
         w_dir_nxt = w_odd_nxt ? DIR_LEFT : DIR_RIGHT;
      end
   end

   // FSM next state and strobes
   always_comb begin
      w_state_nxt      = r_state;
      w_shift_fire     = 1'b0;
      bus.mem_ren      = 1'b0;
      bus.mem_addr     = '0;
      bus.shift_enable = 1'b0;
      bus.done         = 1'b0;
      bus.busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            bus.mem_ren  = 1'b1;
            bus.mem_addr = w_addr;
            if (r_k == c_k_last) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (!bus.hold) begin
               w_shift_fire     = 1'b1;
               bus.shift_enable = 1'b1;
               w_state_nxt      = w_last_slice ? S_FINISH : S_FETCH;
            end
         end
         S_FINISH: begin
            bus.done    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Position, slice capture and window reporting
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_tx        <= 8'd0;
         r_ty        <= 8'd0;
         r_odd       <= 1'b0;
         r_fill      <= 3'd0;
         r_k         <= 3'd0;
         r_dir       <= DIR_NONE;
         r_shift_dir <= DIR_NONE;
         r_buf       <= '0;
         r_win_valid <= 1'b0;
         r_win_x     <= 8'd0;
         r_win_y     <= 8'd0;
      end else begin
         r_win_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_tx   <= 8'd0;
                  r_ty   <= 8'd0;
                  r_odd  <= 1'b0;
                  r_fill <= 3'd0;
                  r_k    <= 3'd0;
                  r_dir  <= DIR_RIGHT;
               end
            end
            S_FETCH: begin
               // Read data lags the strobe by one cycle, so element k-1
               // arrives while element k is being requested.
               for (int i = 0; i < WIN - 1; i++) begin
                  if (r_k == 3'(i + 1)) begin
                     r_buf[i] <= bus.mem_rdata;
                  end
               end
               r_k <= r_k + 3'd1;
            end
            S_CAPTURE: begin
               r_buf[WIN-1] <= bus.mem_rdata;
               r_shift_dir  <= r_dir;
               r_k          <= 3'd0;
            end
            S_SHIFT: begin
               if (w_shift_fire) begin
                  r_tx   <= w_tx_nxt;
                  r_ty   <= w_ty_nxt;
                  r_odd  <= w_odd_nxt;
                  r_fill <= w_fill_nxt;
                  r_dir  <= w_dir_nxt;
                  // The fifth fill shift completes the first window.
                  if (w_fill_nxt == c_fill_len) begin
                     r_win_valid <= 1'b1;
                     r_win_x     <= w_tx_nxt + 8'd2;
                     r_win_y     <= w_ty_nxt + 8'd2;
                  end
               end
            end
            default: begin
               r_k <= 3'd0;
            end
         endcase
      end
   end

   assign bus.shift_direction = r_shift_dir;
   assign bus.buffer_input    = r_buf;
   assign bus.window_valid    = r_win_valid;
   assign bus.win_x           = r_win_x;
   assign bus.win_y           = r_win_y;

endmodule
`default_nettype wire

// File: tb/tb_window_scan_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_window_scan_feeder                                            |
// | Purpose : Self-checking bench for window_scan_feeder: an 8x6 and a 5x5     |
// |           instance, each with a frame memory returning the address.        |
// |           Expected slices come from a serpentine-walk model of the scan.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_window_scan_feeder;
   import window_scan_feeder_pkg::*;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic sel = 1'b0;          // 0: 8x6 instance, 1: 5x5 instance
   logic tb_start = 1'b0;
   logic tb_hold = 1'b0;

   always #5 clk = ~clk;

   window_scan_feeder_if #(.ADDR_W(6)) ifa ();
   window_scan_feeder_if #(.ADDR_W(5)) ifb ();

   window_scan_feeder #(.IMG_W(8), .IMG_H(6), .ADDR_W(6)) dut_a (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (ifa.master)
   );

   window_scan_feeder #(.IMG_W(5), .IMG_H(5), .ADDR_W(5)) dut_b (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (ifb.master)
   );

   assign ifa.start = tb_start & ~sel;
   assign ifa.hold  = tb_hold  & ~sel;
   assign ifb.start = tb_start &  sel;
   assign ifb.hold  = tb_hold  &  sel;

   // Frame memory: pixel value equals its address; junk when not read.
   always @(posedge clk) begin
      ifa.mem_rdata <= ifa.mem_ren ? 8'(ifa.mem_addr) : 8'hEE;
      ifb.mem_rdata <= ifb.mem_ren ? 8'(ifb.mem_addr) : 8'hEE;
   end

   logic        o_se, o_wv, o_done, o_busy, o_ren;
   logic [1:0]  o_dir;
   logic [39:0] o_buf;
   logic [7:0]  o_wx, o_wy, o_addr;

   assign o_se   = sel ? ifb.shift_enable    : ifa.shift_enable;
   assign o_wv   = sel ? ifb.window_valid    : ifa.window_valid;
   assign o_done = sel ? ifb.done            : ifa.done;
   assign o_busy = sel ? ifb.busy            : ifa.busy;
   assign o_ren  = sel ? ifb.mem_ren         : ifa.mem_ren;
   assign o_dir  = sel ? ifb.shift_direction : ifa.shift_direction;
   assign o_buf  = sel ? ifb.buffer_input    : ifa.buffer_input;
   assign o_wx   = sel ? ifb.win_x           : ifa.win_x;
   assign o_wy   = sel ? ifb.win_y           : ifa.win_y;
   assign o_addr = sel ? 8'(ifb.mem_addr)    : 8'(ifa.mem_addr);

   typedef struct {
      logic [1:0]  dir;
      logic [39:0] pix;
      logic        win;
      logic [7:0]  wx;
      logic [7:0]  wy;
   } slice_t;

   slice_t      q[$];
   int          checks = 0;
   int          errors = 0;
   logic [39:0] obs_buf [0:31];
   logic [1:0]  obs_dir [0:31];
   logic [7:0]  last_wx, last_wy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Serpentine walk: 5 fill columns, then per window row a down step
   // (except the first) followed by W-5 horizontal steps.
   task automatic build_model(input int W, input int H);
      slice_t e;
      int     tx, col;
      q.delete();
      for (int c = 0; c < 5; c++) begin
         e.dir = 2'b01;
         for (int k = 0; k < 5; k++) e.pix[k*8 +: 8] = 8'((k*W + c) % 256);
         e.win = (c == 4);
         e.wx  = 8'd2;
         e.wy  = 8'd2;
         q.push_back(e);
      end
      tx = 0;
      for (int r = 0; r <= H - 5; r++) begin
         if (r > 0) begin
            e.dir = 2'b11;
            for (int k = 0; k < 5; k++) e.pix[k*8 +: 8] = 8'(((r+4)*W + tx + k) % 256);
            e.win = 1'b1;
            e.wx  = 8'(tx + 2);
            e.wy  = 8'(r + 2);
            q.push_back(e);
         end
         for (int m = 0; m < W - 5; m++) begin
            if (r % 2 == 0) begin
               col = tx + 5; tx++; e.dir = 2'b01;
            end else begin
               col = tx - 1; tx--; e.dir = 2'b10;
            end
            for (int k = 0; k < 5; k++) e.pix[k*8 +: 8] = 8'(((r+k)*W + col) % 256);
            e.win = 1'b1;
            e.wx  = 8'(tx + 2);
            e.wy  = 8'(r + 2);
            q.push_back(e);
         end
      end
   endtask

   // mode 0: no hold, 1: 10-cycle hold on strobe hs, 2: random hold/start.
   // Inputs change 1 time unit after the rising edge; outputs are read at
   // the falling edge of the same cycle.
   task automatic run_frame(input int W, input int H, input int mode, input int hs,
                            input int extra_start_t, output int t_done);
      int   si, nominal, t, wins, last_se_t;
      logic hold_b, exp_se, exp_done, wv_pend, done_seen;
      logic [7:0] pwx, pwy;
      build_model(W, H);
      si = 0; nominal = 7; wins = 0; last_se_t = -100; t = 0;
      wv_pend = 1'b0; done_seen = 1'b0; t_done = -1; pwx = 8'd0; pwy = 8'd0;
      while (t < 2000 && !done_seen) begin
         @(posedge clk); #1;
         case (mode)
            1:       hold_b = (si == hs) && (t >= nominal) && (t < nominal + 10);
            2:       hold_b = ($urandom_range(0, 2) == 0);
            default: hold_b = 1'b0;
         endcase
         tb_hold  = hold_b;
         tb_start = (t == 0) || (t == extra_start_t) ||
                    (si == q.size() && t == last_se_t + 1) ||
                    (mode == 2 && t > 0 && $urandom_range(0, 9) == 0);
         @(negedge clk);
         check("busy", o_busy, (t > 0));
         check("window_valid", o_wv, wv_pend);
         if (o_wv) begin
            wins++;
            check("win_x", o_wx, pwx);
            check("win_y", o_wy, pwy);
            last_wx = o_wx;
            last_wy = o_wy;
         end
         wv_pend  = 1'b0;
         exp_done = (si == q.size()) && (t == last_se_t + 1);
         check("done", o_done, exp_done);
         if (o_done) begin
            done_seen = 1'b1;
            t_done    = t;
         end
         exp_se = (t >= nominal) && !hold_b && (si < q.size());
         check("strobe_timing", o_se, exp_se);
         if (o_se && si < q.size()) begin
            check("shift_direction", o_dir, q[si].dir);
            check("buffer_input", o_buf, q[si].pix);
            if (si < 32) begin
               obs_buf[si] = o_buf;
               obs_dir[si] = o_dir;
            end
            wv_pend   = q[si].win;
            pwx       = q[si].wx;
            pwy       = q[si].wy;
            si++;
            nominal   = t + 7;
            last_se_t = t;
         end else if (hold_b && t >= nominal && si < q.size()) begin
            check("hold_buffer_stable", o_buf, q[si].pix);
         end
         t++;
      end
      check("frame_done_seen", done_seen, 1'b1);
      check("window_count", wins, (W-4)*(H-4));
      @(posedge clk); #1;
      tb_start = 1'b0;
      tb_hold  = 1'b0;
      @(negedge clk);
      check("idle_after_done", o_busy, 1'b0);
      check("no_strobe_after_done", o_se, 1'b0);
   endtask

   initial begin
      int t_nohold, t_hold, t_tmp;
      logic [1:0] dexp;

      // Reset state
      n_rst = 1'b0;
      sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", o_busy, 1'b0);
      check("rst_shift_enable", o_se, 1'b0);
      check("rst_mem_ren", o_ren, 1'b0);
      check("rst_mem_addr", o_addr, 8'd0);
      check("rst_buffer", o_buf, 40'd0);
      check("rst_dir", o_dir, 2'b00);
      check("rst_window_valid", o_wv, 1'b0);
      check("rst_done", o_done, 1'b0);
      n_rst = 1'b1;

      // Reset in the middle of the first fetch
      @(posedge clk); #1; tb_start = 1'b1;
      @(posedge clk); #1; tb_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_busy", o_busy, 1'b1);
      check("pre_reset_mem_ren", o_ren, 1'b1);
      #2 n_rst = 1'b0;
      #1;
      check("mid_reset_busy", o_busy, 1'b0);
      check("mid_reset_mem_ren", o_ren, 1'b0);
      check("mid_reset_shift_enable", o_se, 1'b0);
      check("mid_reset_buffer", o_buf, 40'd0);
      repeat (3) begin
         @(negedge clk);
         check("reset_no_done", o_done, 1'b0);
      end
      @(posedge clk); #1; n_rst = 1'b1;

      // Full 8x6 frame, no stall
      run_frame(8, 6, 0, 0, -1, t_nohold);
      check("frame_cycles_nohold", t_nohold, 85);
      check("first_fill_slice", obs_buf[0], 40'h20_18_10_08_00);
      check("down_slice", obs_buf[8], 40'h2F_2E_2D_2C_2B);
      check("left_after_down", obs_buf[9], 40'h2A_22_1A_12_0A);
      for (int i = 0; i < 12; i++) begin
         dexp = (i < 8) ? 2'b01 : ((i == 8) ? 2'b11 : 2'b10);
         check("dir_sequence", obs_dir[i], dexp);
      end
      check("last_win_x", last_wx, 8'd2);
      check("last_win_y", last_wy, 8'd3);

      // 10-cycle hold on the fourth strobe
      run_frame(8, 6, 1, 3, -1, t_hold);
      check("hold_extends_frame", t_hold - t_nohold, 10);

      // start pulsed while busy
      run_frame(8, 6, 0, 0, 30, t_tmp);
      check("start_while_busy_frame", t_tmp, t_nohold);

      // Random stalls and stray start pulses
      run_frame(8, 6, 2, 0, -1, t_tmp);
      run_frame(8, 6, 2, 0, -1, t_tmp);

      // Minimum 5x5 image
      sel = 1'b1;
      @(posedge clk); #1;
      run_frame(5, 5, 0, 0, -1, t_tmp);
      check("frame5_cycles", t_tmp, 36);
      check("frame5_win_x", last_wx, 8'd2);
      check("frame5_win_y", last_wy, 8'd2);
      run_frame(5, 5, 2, 0, -1, t_tmp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
